// File: rtl/apb_regfile_pkg.sv
// Shared types for the APB register-file completer: FSM states, register
// access attributes and the wait-state counter width.
package apb_regfile_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef enum logic [1:0] {
        ATTR_RW    = 2'd0,
        ATTR_RO    = 2'd1,
        ATTR_WO    = 2'd2,
        ATTR_FIXED = 2'd3
    } reg_attr_e;

    // Wide enough for the largest wait-state setting (15).
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_access_decode.sv
// Combinational address/attribute decode: resolves a register's access
// attribute and whether the requested access is an error. No latency, no backpressure.
module apb_access_decode
    import apb_regfile_pkg::*;
#(
    parameter int               DEPTH      = 8,
    parameter int               ADDR_W     = 3,
    parameter int               STRB_W     = 4,
    parameter logic [DEPTH-1:0] RO_MASK    = '0,
    parameter logic [DEPTH-1:0] WO_MASK    = '0,
    parameter logic [DEPTH-1:0] FIXED_MASK = '0
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              write,
    input  logic [STRB_W-1:0] strb,
    output reg_attr_e         attr,
    output logic              err
);

    logic out_of_range;

    // Only a non-power-of-two DEPTH leaves unused address codes.
    generate
        if ((1 << ADDR_W) > DEPTH) begin : g_range
            assign out_of_range = (addr >= ADDR_W'(DEPTH));
        end else begin : g_full
            assign out_of_range = 1'b0;
        end
    endgenerate

    // A register flagged both RO and WO resolves to RO.
    always_comb begin
        attr = ATTR_RW;
        if (!out_of_range) begin
            if (FIXED_MASK[addr])   attr = ATTR_FIXED;
            else if (RO_MASK[addr]) attr = ATTR_RO;
            else if (WO_MASK[addr]) attr = ATTR_WO;
        end
    end

    always_comb begin
        err = 1'b0;
        if (out_of_range)
            err = 1'b1;
        else if (write)
            err = (attr == ATTR_RO) || (attr == ATTR_FIXED);
        else
            err = (attr == ATTR_WO) || (strb != '0);
    end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB completer over a DEPTH x DATA_W register file; APB_STRB_EN adds byte strobes.
// Transfer takes 2+WAIT_CYCLES cycles; the requester is stalled by p_ready low during wait states.
module apb_regfile_slave
    import apb_regfile_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 8,
    parameter int                ADDR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int                WAIT_CYCLES = 0,
    parameter logic [DEPTH-1:0]  RO_MASK     = '0,
    parameter logic [DEPTH-1:0]  WO_MASK     = '0,
    parameter logic [DEPTH-1:0]  FIXED_MASK  = '0,
    parameter logic [DATA_W-1:0] FIXED_VALUE = DATA_W'(19)
) (
    input  logic                  p_clk,
    input  logic                  p_reset,
    input  logic                  p_sel,
    input  logic                  p_enable,
    input  logic                  p_write,
    input  logic [ADDR_W-1:0]     p_addr,
    input  logic [DATA_W-1:0]     p_w_data,
`ifdef APB_STRB_EN
    input  logic [DATA_W/8-1:0]   p_strb,
`endif
    output logic                  p_ready,
    output logic [DATA_W-1:0]     p_r_data,
    output logic                  p_slv_err
);

    localparam int                    STRB_W    = DATA_W / 8;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_CYCLES);

    apb_state_e              state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q;
    logic                    s_write_q, s_err_q;
    logic [ADDR_W-1:0]       s_addr_q;
    logic [DATA_W-1:0]       s_wdata_q;
    logic [STRB_W-1:0]       s_lanes_q;
    logic [DATA_W-1:0]       regs_q [DEPTH];
    logic [DATA_W-1:0]       rd_dat_q, rd_next;
    logic [STRB_W-1:0]       dec_strb, wr_lanes;
    reg_attr_e               dec_attr;
    logic                    dec_err, sample, commit;

`ifdef APB_STRB_EN
    assign dec_strb = p_strb;
    assign wr_lanes = p_strb;
`else
    assign dec_strb = '0;
    assign wr_lanes = '1;
`endif

    apb_access_decode #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .STRB_W     (STRB_W),
        .RO_MASK    (RO_MASK),
        .WO_MASK    (WO_MASK),
        .FIXED_MASK (FIXED_MASK)
    ) u_decode (
        .addr  (p_addr),
        .write (p_write),
        .strb  (dec_strb),
        .attr  (dec_attr),
        .err   (dec_err)
    );

    assign sample = (state_q == SETUP) && p_sel;
    assign commit = p_ready && s_write_q && !s_err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (p_sel && !p_enable) state_d = SETUP;
            SETUP:   state_d = p_sel ? ACCESS : IDLE;
            ACCESS: begin
                if (!p_sel)       state_d = IDLE;
                else if (p_ready) state_d = p_enable ? IDLE : SETUP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs come from registered state only, so no input reaches them combinationally.
    always_comb begin
        p_ready   = 1'b0;
        p_slv_err = 1'b0;
        if (state_q == ACCESS && wait_cnt_q == WAIT_LAST) begin
            p_ready   = 1'b1;
            p_slv_err = s_err_q;
        end
    end

    always_comb begin
        rd_next = '0;
        if (!dec_err)
            rd_next = (dec_attr == ATTR_FIXED) ? FIXED_VALUE : regs_q[p_addr];
    end

    always_ff @(posedge p_clk) begin
        if (p_reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            s_write_q  <= 1'b0;
            s_err_q    <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            s_lanes_q  <= '0;
            rd_dat_q   <= '0;
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ACCESS && !p_ready)
                wait_cnt_q <= wait_cnt_q + WAIT_CNT_W'(1);
            else
                wait_cnt_q <= '0;
            if (sample) begin
                s_write_q <= p_write;
                s_err_q   <= dec_err;
                s_addr_q  <= p_addr;
                s_wdata_q <= p_w_data;
                s_lanes_q <= wr_lanes;
                if (!p_write) rd_dat_q <= rd_next;
            end
            if (commit) begin
                for (int b = 0; b < STRB_W; b++)
                    if (s_lanes_q[b]) regs_q[s_addr_q][8*b +: 8] <= s_wdata_q[8*b +: 8];
            end
        end
    end

    assign p_r_data = rd_dat_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Two completer instances (no-wait DEPTH=6 with attributes, 3-wait DEPTH=8),
// directed vector table, hand corner sequences and a randomized model check.
module tb_apb_regfile_slave;

`ifdef APB_STRB_EN
    localparam bit STRB_EN = 1'b1;
`else
    localparam bit STRB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        sel  [2];
    logic        en   [2];
    logic        wr   [2];
    logic [2:0]  addr [2];
    logic [31:0] wdat [2];
`ifdef APB_STRB_EN
    logic [3:0]  strb [2];
`endif
    logic        rdy  [2];
    logic        err  [2];
    logic [31:0] rdat [2];

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_reg [2][8];
    logic [31:0] m_rd  [2];

    always #5 clk = ~clk;

    apb_regfile_slave #(
        .DATA_W(32), .DEPTH(6), .WAIT_CYCLES(0),
        .RO_MASK(6'b010010), .WO_MASK(6'b100010), .FIXED_MASK(6'b001000),
        .FIXED_VALUE(32'd19)
    ) u_dut0 (
        .p_clk(clk), .p_reset(rst), .p_sel(sel[0]), .p_enable(en[0]),
        .p_write(wr[0]), .p_addr(addr[0]), .p_w_data(wdat[0]),
`ifdef APB_STRB_EN
        .p_strb(strb[0]),
`endif
        .p_ready(rdy[0]), .p_r_data(rdat[0]), .p_slv_err(err[0])
    );

    apb_regfile_slave #(
        .DATA_W(32), .DEPTH(8), .WAIT_CYCLES(3),
        .RO_MASK(8'h00), .WO_MASK(8'h80), .FIXED_MASK(8'h00),
        .FIXED_VALUE(32'd19)
    ) u_dut1 (
        .p_clk(clk), .p_reset(rst), .p_sel(sel[1]), .p_enable(en[1]),
        .p_write(wr[1]), .p_addr(addr[1]), .p_w_data(wdat[1]),
`ifdef APB_STRB_EN
        .p_strb(strb[1]),
`endif
        .p_ready(rdy[1]), .p_r_data(rdat[1]), .p_slv_err(err[1])
    );

    // Resolved register attributes of the two instances.
    function automatic int dep(input int d);
        return (d == 0) ? 6 : 8;
    endfunction
    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction
    function automatic bit is_fixed(input int d, input int a);
        return (d == 0) && (a == 3);
    endfunction
    function automatic bit is_ro(input int d, input int a);
        return (d == 0) && (a == 1 || a == 4);
    endfunction
    function automatic bit is_wo(input int d, input int a);
        return ((d == 0) && (a == 5)) || ((d == 1) && (a == 7));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_rd[d] = '0;
            for (int a = 0; a < 8; a++) m_reg[d][a] = '0;
        end
    endtask

    task automatic model_xfer(input int d, input bit w, input int a, input logic [31:0] wd,
                              input logic [3:0] sb, output bit e_err, output logic [31:0] e_rd);
        e_err = (a >= dep(d)) || (w && (is_ro(d, a) || is_fixed(d, a))) ||
                (!w && is_wo(d, a)) || (!w && STRB_EN && sb != 4'h0);
        if (!w)
            m_rd[d] = e_err ? 32'h0 : (is_fixed(d, a) ? 32'd19 : m_reg[d][a]);
        else if (!e_err)
            for (int b = 0; b < 4; b++)
                if (!STRB_EN || sb[b]) m_reg[d][a][8*b +: 8] = wd[8*b +: 8];
        e_rd = m_rd[d];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts at #1 after an edge; returns in the completion cycle with the bus
    // still selected, so a following call chains back-to-back.
    task automatic xfer(input int d, input bit w, input int a, input logic [31:0] wd,
                        input logic [3:0] sb, output logic [31:0] rd, output logic er,
                        output int lat);
        sel[1-d] = 1'b0; en[1-d] = 1'b0;
        sel[d] = 1'b1; en[d] = 1'b0; wr[d] = w; addr[d] = 3'(a); wdat[d] = wd;
`ifdef APB_STRB_EN
        strb[d] = sb;
`endif
        @(posedge clk); #1;
        check("setup ready", 32'(rdy[d]), 32'h0);
        en[d] = 1'b1;
        @(posedge clk); #1;
        // Scramble the bus after sampling; the completer must ignore it.
        addr[d] = 3'($urandom); wdat[d] = $urandom; wr[d] = 1'($urandom);
`ifdef APB_STRB_EN
        strb[d] = 4'($urandom);
`endif
        lat = 0;
        while (rdy[d] !== 1'b1 && lat < 20) begin
            check("err during wait", 32'(err[d]), 32'h0);
            @(posedge clk); #1;
            lat++;
        end
        rd = rdat[d];
        er = err[d];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            sel[0] = 1'b0; en[0] = 1'b0; sel[1] = 1'b0; en[1] = 1'b0;
            @(posedge clk); #1;
            check("idle ready", 32'({rdy[1], rdy[0]}), 32'h0);
            check("idle err",   32'({err[1], err[0]}), 32'h0);
        end
    endtask

    task automatic run(input int d, input bit w, input int a, input logic [31:0] wd,
                       input logic [3:0] sb, input string tag);
        bit          e_err;
        logic [31:0] e_rd, rd;
        logic        er;
        int          lat;
        model_xfer(d, w, a, wd, sb, e_err, e_rd);
        xfer(d, w, a, wd, sb, rd, er, lat);
        check({tag, " err"},   32'(er), 32'(e_err));
        check({tag, " rdata"}, rd, e_rd);
        check({tag, " wait"},  32'(lat), 32'(wait_of(d)));
    endtask

    typedef struct {
        int          d;
        bit          w;
        int          a;
        logic [31:0] wd;
        logic [3:0]  sb;
        bit          e_err;
        logic [31:0] e_rd;
    } vec_t;

    function automatic vec_t mk(input int d, input bit w, input int a, input logic [31:0] wd,
                                input logic [3:0] sb, input bit e_err, input logic [31:0] e_rd);
        vec_t v;
        v.d = d; v.w = w; v.a = a; v.wd = wd; v.sb = sb; v.e_err = e_err; v.e_rd = e_rd;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [$];
        bit          me;
        logic [31:0] mr, rd;
        logic        er;
        int          lat, rd_d, ra;
        bit          rw;
        logic [3:0]  rsb;

        tbl.push_back(mk(0, 1, 2, 32'hDEADBEEF, 4'hF, 0, 32'h0));
        tbl.push_back(mk(0, 0, 2, 32'h0,        4'h0, 0, 32'hDEADBEEF));
        tbl.push_back(mk(0, 1, 3, 32'h55,       4'hF, 1, 32'h0));
        tbl.push_back(mk(0, 0, 3, 32'h0,        4'h0, 0, 32'd19));
        tbl.push_back(mk(0, 0, 5, 32'h0,        4'h0, 1, 32'h0));
        tbl.push_back(mk(0, 1, 5, 32'h12345678, 4'hF, 0, 32'h0));
        tbl.push_back(mk(0, 0, 5, 32'h0,        4'h0, 1, 32'h0));
        tbl.push_back(mk(0, 1, 4, 32'h1,        4'hF, 1, 32'h0));
        tbl.push_back(mk(0, 0, 4, 32'h0,        4'h0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 1, 32'hFFFF,     4'hF, 1, 32'h0));
        tbl.push_back(mk(0, 0, 1, 32'h0,        4'h0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 7, 32'hCAFEF00D, 4'hF, 1, 32'h0));
        tbl.push_back(mk(0, 0, 6, 32'h0,        4'h0, 1, 32'h0));
        tbl.push_back(mk(0, 0, 2, 32'h0,        4'h0, 0, 32'hDEADBEEF));
        tbl.push_back(mk(0, 1, 0, 32'hA5A5A5A5, 4'hF, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,        4'h0, 0, 32'hA5A5A5A5));
        tbl.push_back(mk(1, 0, 0, 32'h0,        4'h0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 1, 32'h11223344, 4'hF, 0, 32'h0));
        tbl.push_back(mk(1, 0, 1, 32'h0,        4'h0, 0, 32'h11223344));
`ifdef APB_STRB_EN
        tbl.push_back(mk(1, 1, 1, 32'hAABBCCDD, 4'b0101, 0, 32'h0));
        tbl.push_back(mk(1, 0, 1, 32'h0,        4'h0, 0, 32'h11BB33DD));
        tbl.push_back(mk(1, 1, 1, 32'h0,        4'h0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 1, 32'h0,        4'h0, 0, 32'h11BB33DD));
        tbl.push_back(mk(1, 0, 1, 32'h0,        4'h2, 1, 32'h0));
`else
        tbl.push_back(mk(1, 1, 1, 32'hAABBCCDD, 4'b0101, 0, 32'h0));
        tbl.push_back(mk(1, 0, 1, 32'h0,        4'h0, 0, 32'hAABBCCDD));
        tbl.push_back(mk(1, 1, 1, 32'h0,        4'h0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 1, 32'h0,        4'h0, 0, 32'h0));
`endif
        tbl.push_back(mk(1, 0, 7, 32'h0,        4'h0, 1, 32'h0));
        tbl.push_back(mk(1, 1, 7, 32'h77,       4'hF, 0, 32'h0));
        tbl.push_back(mk(1, 0, 6, 32'h0,        4'h0, 0, 32'h0));

        for (int d = 0; d < 2; d++) begin
            sel[d] = 1'b0; en[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdat[d] = '0;
`ifdef APB_STRB_EN
            strb[d] = '0;
`endif
        end
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check("reset ready", 32'(rdy[d]), 32'h0);
            check("reset err",   32'(err[d]), 32'h0);
            check("reset rdata", rdat[d],     32'h0);
        end

        // Directed vectors; odd entries chain straight into the next transfer.
        foreach (tbl[i]) begin
            model_xfer(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].sb, me, mr);
            xfer(tbl[i].d, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].sb, rd, er, lat);
            check($sformatf("vec%0d err", i), 32'(er), 32'(tbl[i].e_err));
            check($sformatf("vec%0d wait", i), 32'(lat), 32'(wait_of(tbl[i].d)));
            if (!tbl[i].w) check($sformatf("vec%0d rdata", i), rd, tbl[i].e_rd);
            if (i % 2 == 0) idle(1);
        end
        idle(1);

        // Abort: drop p_sel during a wait state of a write.
        run(1, 1, 2, 32'h0BADCAFE, 4'hF, "abort pre-write");
        idle(1);
        sel[1] = 1'b1; en[1] = 1'b0; wr[1] = 1'b1; addr[1] = 3'd2; wdat[1] = 32'hFFFFFFFF;
`ifdef APB_STRB_EN
        strb[1] = 4'hF;
`endif
        @(posedge clk); #1;
        en[1] = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        check("abort mid-wait ready", 32'(rdy[1]), 32'h0);
        sel[1] = 1'b0;
        @(posedge clk); #1;
        check("abort ready", 32'(rdy[1]), 32'h0);
        check("abort err",   32'(err[1]), 32'h0);
        idle(4);
        run(1, 0, 2, 32'h0, 4'h0, "abort readback");
        idle(1);

        // Reset in the middle of a write.
        sel[1] = 1'b1; en[1] = 1'b0; wr[1] = 1'b1; addr[1] = 3'd3; wdat[1] = 32'h13579BDF;
        @(posedge clk); #1;
        en[1] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; sel[1] = 1'b0; en[1] = 1'b0;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            check("midreset ready", 32'(rdy[d]), 32'h0);
            check("midreset err",   32'(err[d]), 32'h0);
            check("midreset rdata", rdat[d],     32'h0);
        end
        idle(2);
        run(1, 0, 3, 32'h0, 4'h0, "midreset readback");
        run(1, 0, 2, 32'h0, 4'h0, "midreset reg2");
        idle(1);

        // Randomized traffic against the model, mixing chained and gapped transfers.
        for (int i = 0; i < 400; i++) begin
            rd_d = $urandom_range(0, 1);
            rw   = 1'($urandom_range(0, 1));
            ra   = $urandom_range(0, 7);
            rsb  = 4'($urandom);
            if (!rw && $urandom_range(0, 3) != 0) rsb = 4'h0;
            run(rd_d, rw, ra, $urandom, rsb, $sformatf("rand%0d", i));
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
